pipe_stall_ctrl: RTL and testbench

- Central stall controller for the 5-stage pipeline; generates the `StallBus` vector consumed by the PC, IF, ID, EX, MEM and WB pipeline registers.
- Detects ID-stage load-use hazards and sequences the multi-cycle divider in EX through a counter FSM.
- Holds the pipeline while a data-SRAM access in MEM is unacknowledged.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 5-stage pipeline: load-use, divider and data-SRAM holds.
// Ports: clk/rst; ID operand fields and use flags; EX load/write-back info; div_start level;
//        MEM req/ack; outputs stall[5:0] (bit0 PC .. bit5 WB, 1 = stop), div_busy, div_done, stall_cnt.
module pipe_stall_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        ex_is_load,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic        div_start,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [5:0]  stall,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // The IDLE cycle that accepts div_start is already the first cycle of the
  // divide, so BUSY only has to cover the remaining DIV_LAT-1 cycles.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_pending_q;
  logic             load_use;
  logic             ex_req;
  logic             mem_req_stall;

  always_comb begin
    load_use = ex_is_load & ex_wreg & (ex_waddr != 5'd0) &
               ((id_rs_used & (id_rs == ex_waddr)) |
                (id_rt_used & (id_rt == ex_waddr)));
    // A pending result means the div in EX is the one that already finished;
    // its still-high div_start must not launch a second divide.
    ex_req        = div_start & ~div_pending_q & ((state_q == IDLE) | (state_q == BUSY));
    mem_req_stall = mem_req & ~mem_ack;

    stall = STALL_NONE;
    if (rst) begin
      stall = STALL_NONE;
    end else if (mem_req_stall) begin
      stall = STALL_MEM;
    end else if (ex_req) begin
      stall = STALL_EX;
    end else if (load_use) begin
      stall = STALL_ID;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (div_start & ~div_pending_q) begin
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Keeps counting under a MEM stall: the divider runs on its own.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_pending_q <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Result finished while EX is frozen: remember it until EX finally moves.
      if (stall[3]) begin
        div_pending_q <= div_pending_q | (state_q == DONE);
      end else begin
        div_pending_q <= 1'b0;
      end
      if (stall[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign div_busy = (state_q == BUSY) & ~rst;
  assign div_done = (state_q == DONE) & ~rst;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus a randomized run against
// a cycle-level reference model (divide tracked as an age since its start).
module tb_pipe_stall_ctrl;

  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_waddr;
  logic        id_rs_used, id_rt_used, ex_is_load, ex_wreg;
  logic        div_start, mem_req, mem_ack;
  logic [5:0]  stall;
  logic        div_busy, div_done;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .div_start(div_start), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  bit          m_active;  // a divide is in flight
  int          m_age;     // cycles elapsed since the accepted div_start cycle
  bit          m_pend;    // finished result waiting for a frozen EX
  logic [31:0] m_cnt;
  logic [5:0]  e_stall;
  bit          e_done, e_busy, e_start;

  task automatic model_eval();
    bit lu, ms, exh;
    e_done = 0; e_busy = 0; e_start = 0; exh = 0;
    if (rst) begin
      e_stall = 6'h00;
    end else begin
      lu = ex_is_load && ex_wreg && (ex_waddr != 0) &&
           ((id_rs_used && id_rs == ex_waddr) || (id_rt_used && id_rt == ex_waddr));
      ms = mem_req && !mem_ack;
      if (m_active) begin
        exh    = (m_age < DIV_LAT);
        e_done = (m_age == DIV_LAT);
        e_busy = (m_age >= 1 && m_age < DIV_LAT);
      end else if (div_start && !m_pend) begin
        exh = 1; e_start = 1;
      end
      e_stall = ms ? 6'b011111 : exh ? 6'b001111 : lu ? 6'b000111 : 6'b000000;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_active = 0; m_age = 0; m_pend = 0; m_cnt = 0;
    end else begin
      if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_active && e_done) begin
        m_active = 0;
        m_pend   = e_stall[3];
      end else begin
        if (m_active) m_age++;
        if (e_start) begin m_active = 1; m_age = 1; end
        if (!e_stall[3]) m_pend = 0;
      end
    end
  endtask

  task automatic at_sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    ex_is_load = 0; ex_wreg = 0; ex_waddr = 0; div_start = 0; mem_req = 0; mem_ack = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1; div_start = 1; mem_req = 1; ex_is_load = 1; ex_wreg = 1; ex_waddr = 3;
    id_rs = 3; id_rs_used = 1;
    for (int c = 0; c < 2; c++) begin
      at_sample();
      checks++;
      if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall); end
      checks++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
        errors++; $display("FAIL reset_div got busy=%b done=%b exp 0/0", div_busy, div_done);
      end
      advance();
    end
    clear_inputs();
    at_sample();
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    advance();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 5; id_rs = 5; id_rs_used = 1;
    at_sample();
    checks++;
    if (stall !== 6'b000111) begin errors++; $display("FAIL load_use got=%b exp=000111", stall); end
    advance();
    clear_inputs();
    at_sample();
    checks++;
    if (stall_cnt !== 32'd1 || stall !== 6'b0) begin
      errors++; $display("FAIL load_use_after got cnt=%0d stall=%b exp 1/000000", stall_cnt, stall);
    end
    advance();
    for (int k = 0; k < 4; k++) begin
      logic [5:0] exp;
      ex_is_load = 1; ex_wreg = 1; ex_waddr = 5; id_rs = 5; id_rs_used = 1;
      id_rt = 0; id_rt_used = 0; exp = 6'b000000;
      case (k)
        0: ex_waddr = 0;
        1: id_rs_used = 0;
        2: ex_wreg = 0;
        default: begin id_rs = 1; id_rt = 5; id_rt_used = 1; exp = 6'b000111; end
      endcase
      if (k == 0) id_rs = 0;
      at_sample();
      checks++;
      if (stall !== exp) begin errors++; $display("FAIL load_use_case%0d got=%b exp=%b", k, stall, exp); end
      advance();
    end
    clear_inputs();
    at_sample();
    checks++;
    if (stall_cnt !== 32'd2) begin errors++; $display("FAIL load_use_cnt got=%0d exp=2", stall_cnt); end
    advance();
  endtask

  task automatic test_divide();
    int n_stall, n_busy, done_cyc;
    clear_inputs();
    div_start = 1;
    n_stall = 0; n_busy = 0; done_cyc = 0;
    for (int c = 1; c <= DIV_LAT + 1; c++) begin
      at_sample();
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL div_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      if (stall == 6'b001111) n_stall++;
      if (div_busy) n_busy++;
      if (div_done) begin
        done_cyc = c;
        checks++;
        if (stall !== 6'b0) begin errors++; $display("FAIL div_done_stall got=%b exp=000000", stall); end
      end
      advance();
    end
    div_start = 0;
    checks++;
    if (n_stall != DIV_LAT) begin errors++; $display("FAIL div_hold got=%0d exp=%0d", n_stall, DIV_LAT); end
    checks++;
    if (n_busy != DIV_LAT - 1) begin errors++; $display("FAIL div_busy_len got=%0d exp=%0d", n_busy, DIV_LAT - 1); end
    checks++;
    if (done_cyc != DIV_LAT + 1) begin errors++; $display("FAIL div_done_cyc got=%0d exp=%0d", done_cyc, DIV_LAT + 1); end
    at_sample();
    checks++;
    if (div_busy !== 0 || div_done !== 0 || stall !== 0) begin
      errors++; $display("FAIL div_idle got busy=%b done=%b stall=%b exp 0/0/000000", div_busy, div_done, stall);
    end
    advance();
  endtask

  task automatic test_priority();
    clear_inputs();
    mem_req = 1; mem_ack = 0; div_start = 1;
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 7; id_rt = 7; id_rt_used = 1;
    at_sample();
    checks++;
    if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem got=%b exp=011111", stall); end
    advance();
    mem_ack = 1;
    at_sample();
    checks++;
    if (stall !== 6'b001111) begin errors++; $display("FAIL prio_ex got=%b exp=001111", stall); end
    advance();
    mem_req = 0; mem_ack = 0;
    for (int c = 0; c < DIV_LAT + 4 && m_active; c++) begin
      at_sample();
      checks++;
      if (stall !== e_stall || div_done !== e_done) begin
        errors++; $display("FAIL prio_drain got=%b/%b exp=%b/%b", stall, div_done, e_stall, e_done);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_done_under_mem();
    clear_inputs();
    div_start = 1;
    for (int c = 1; c <= DIV_LAT + 1; c++) begin
      if (c == DIV_LAT - 2) begin mem_req = 1; mem_ack = 0; end
      at_sample();
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL dmem_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      if (c == DIV_LAT + 1) begin
        checks++;
        if (div_done !== 1'b1 || stall !== 6'b011111) begin
          errors++; $display("FAIL dmem_done got done=%b stall=%b exp 1/011111", div_done, stall);
        end
      end
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      at_sample();
      checks++;
      if (stall !== 6'b011111 || div_busy !== 0 || div_done !== 0) begin
        errors++; $display("FAIL dmem_frozen got stall=%b busy=%b done=%b exp 011111/0/0", stall, div_busy, div_done);
      end
      advance();
    end
    mem_ack = 1;
    at_sample();
    checks++;
    if (stall !== 6'b000000) begin errors++; $display("FAIL dmem_release got=%b exp=000000", stall); end
    advance();
    clear_inputs();
    at_sample();
    checks++;
    if (stall !== 0 || div_busy !== 0) begin
      errors++; $display("FAIL dmem_after got stall=%b busy=%b exp 000000/0", stall, div_busy);
    end
    advance();
  endtask

  task automatic test_reset_mid_divide();
    int n_done;
    clear_inputs();
    div_start = 1;
    for (int c = 0; c < 11; c++) begin at_sample(); advance(); end
    rst = 1;
    at_sample();
    checks++;
    if (stall !== 6'b0) begin errors++; $display("FAIL rstdiv_stall got=%b exp=000000", stall); end
    advance();
    clear_inputs();
    at_sample();
    checks++;
    if (div_busy !== 0 || stall_cnt !== 32'd0 || stall !== 0) begin
      errors++; $display("FAIL rstdiv_after got busy=%b cnt=%0d stall=%b exp 0/0/000000", div_busy, stall_cnt, stall);
    end
    advance();
    n_done = 0;
    for (int c = 0; c < DIV_LAT + 8; c++) begin
      at_sample();
      if (div_done) n_done++;
      advance();
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL rstdiv_no_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 399) == 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_waddr   = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1));
      id_rt_used = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_wreg    = 1'($urandom_range(0, 1));
      mem_req    = ($urandom_range(0, 2) == 0);
      mem_ack    = 1'($urandom_range(0, 1));
      if (m_active && m_age < DIV_LAT) div_start = 1;
      else if (m_pend) div_start = 1'($urandom_range(0, 1));
      else div_start = ($urandom_range(0, 9) == 0);
      at_sample();
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      checks++;
      if (div_done !== e_done || div_busy !== e_busy) begin
        errors++; $display("FAIL rnd_div c=%0d got done=%b busy=%b exp %b/%b", c, div_done, div_busy, e_done, e_busy);
      end
      checks++;
      if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_active = 0; m_age = 0; m_pend = 0; m_cnt = 0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_divide();
    test_priority();
    test_done_under_mem();
    test_reset_mid_divide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
